uart_command_decoder: RTL and testbench
=======================================

// Module: uart_command_decoder
// PURPOSE
//  Consumes 40-bit command frames from the UART protocol RX FIFO (RX_Fifo_Data/RX_FIFO_EMPTY/RX_FIFO_RE).
//  Executes each frame as a register read, register write or NOP on a simple ready-handshake register bus.
//  Pushes a 40-bit response frame into the TX FIFO side of the UART protocol block.
//  Runs in the Logic_Clock domain, downstream of the RX CDC FIFO and upstream of the TX FIFO.
// PARAMETERS
//  ADDR_W          6    register address width; fixed by the frame format, do not override
//  TIMEOUT_CYCLES  255  BUS-state cycles without Reg_Ready before a timeout error (1..65535)
// PORTS
//  Clock          in   1       Logic clock; single clock domain
//  Reset_N        in   1       synchronous, active-low reset
//  RX_FIFO_EMPTY  in   1       RX FIFO empty flag
//  RX_FIFO_RE     out  1       RX FIFO read enable; Q is valid 1 cycle later
//  RX_Fifo_Data   in   40      RX FIFO Q: [39:38] op, [37:32] addr, [31:0] data
//  TX_FIFO_FULL   in   1       TX FIFO full flag
//  TX_FIFO_WE     out  1       TX FIFO write enable
//  TX_Fifo_Data   out  40      response frame: [39:38] op, [37:32] addr, [31:0] payload
//  Reg_Addr       out  ADDR_W  register address
//  Reg_WData      out  32      register write data
//  Reg_WE         out  1       write strobe; held until Reg_Ready
//  Reg_RE         out  1       read strobe; held until Reg_Ready
//  Reg_RData      in   32      read data; valid in the cycle Reg_Ready=1
//  Reg_Ready      in   1       bus completion
//  Busy           out  1       high in every state except IDLE
//  Error_Count    out  8       number of error responses; saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs registered and reset to 0; state=IDLE; Error_Count=0.
//  Reset mid-operation: the in-flight frame is discarded, strobes drop, and no response is sent.
//  Opcodes: 00 NOP, 01 WRITE, 10 READ, 11 illegal.
//  FSM transitions:
//   IDLE   -> POP    when RX_FIFO_EMPTY=0
//   POP    : RX_FIFO_RE=1 for exactly 1 cycle, then WAIT
//   WAIT   : latch RX_Fifo_Data into frame register, then DECODE
//   DECODE : NOP -> IDLE (no bus access, no response)
//            11  -> RESP with error 32'h1
//            01/10 -> BUS; Reg_Addr, Reg_WData and strobe asserted on entry
//   BUS    : strobe held until Reg_Ready=1
//            Reg_Ready=1: strobe drops next cycle; READ latches Reg_RData; -> RESP
//            timeout counter reaches TIMEOUT_CYCLES with no Reg_Ready: strobe drops,
//              error 32'h2 -> RESP; a late Reg_Ready is ignored
//            WRITE without CMD_WRITE_ACK_EN: Reg_Ready -> IDLE (no response)
//   RESP   : TX_FIFO_WE=1 for 1 cycle only when TX_FIFO_FULL=0, then IDLE
//            while FULL: WE=0 and TX_Fifo_Data held stable; wait indefinitely
//  Response formats:
//   READ : {2'b10, addr, rdata}
//   ACK  : {2'b01, addr, wdata}
//   ERROR: {2'b11, addr, code}; Error_Count increments in the same cycle as WE
//  Latency: READ with Reg_Ready in the 1st BUS cycle -> TX_FIFO_WE 5 cycles after EMPTY is sampled low.
//  Throughput: at most 1 frame in flight; RX_FIFO_RE never asserts outside POP.
//  Timeout counter: 16 bit, cleared on BUS entry.
// CONFIGURATION
//  CMD_WRITE_ACK_EN defined: a completed WRITE sends the ACK frame.
//  CMD_WRITE_ACK_EN undefined: a completed WRITE returns to IDLE with no response.
//  Errors are reported in both builds.
// TESTING
//  1. RX frame 40'h82_0000_0000 (READ addr 2), Reg_Ready=1 w/ RData 32'hDEADBEEF in 1st BUS cycle
//     -> TX_Fifo_Data=40'h82DEADBEEF, WE pulse 5 cycles after EMPTY falls.
//  2. RX frame 40'h45_1234_5678 (WRITE addr 5)
//     -> Reg_WE high until Ready with Reg_Addr=5, Reg_WData=32'h12345678;
//        with ACK_EN: TX 40'h4512345678; without ACK_EN: no TX write.
//  3. RX frame 40'hC0_0000_0000
//     -> no bus strobe; TX 40'hC000000001; Error_Count=1.
//  4. READ with Reg_Ready held low, TIMEOUT_CYCLES=255
//     -> Reg_RE drops after 255 BUS cycles; TX {2'b10→2'b11,addr,32'h2}=40'hC_ _ ..02; Error_Count increments.
//  5. TX_FIFO_FULL=1 for 20 cycles during RESP
//     -> WE stays 0 and data stays stable; exactly 1 WE pulse after FULL falls.
//  6. Reset_N=0 for 1 cycle during BUS, then 3 frames back-to-back
//     -> outputs return to 0 and the aborted frame gets no response;
//        the 3 frames are processed in order with exactly 3 RE pulses.

Source files
------------

// File: rtl/uart_command_decoder.sv
// uart_command_decoder
// Pulls 40-bit command frames from the UART RX FIFO and executes each one as a
// register read, register write or NOP on a ready-handshake register bus. It
// then pushes a 40-bit response frame into the UART TX FIFO.
// Frame layout: [39:38] op (00 NOP, 01 WRITE, 10 READ, 11 illegal),
// [37:32] address, [31:0] data.
// Optional build macro: CMD_WRITE_ACK_EN. When it is defined, a completed WRITE
// returns an ACK frame. Without it, a completed WRITE sends no response.
module uart_command_decoder #(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              RX_FIFO_EMPTY,
    output logic              RX_FIFO_RE,
    input  logic [39:0]       RX_Fifo_Data,
    input  logic              TX_FIFO_FULL,
    output logic              TX_FIFO_WE,
    output logic [39:0]       TX_Fifo_Data,
    output logic [ADDR_W-1:0] Reg_Addr,
    output logic [31:0]       Reg_WData,
    output logic              Reg_WE,
    output logic              Reg_RE,
    input  logic [31:0]       Reg_RData,
    input  logic              Reg_Ready,
    output logic              Busy,
    output logic [7:0]        Error_Count
);

    localparam int unsigned FRAME_W     = 40;
    localparam int unsigned CNT_W       = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]  OP_NOP      = 2'b00;
    localparam logic [1:0]  OP_WRITE    = 2'b01;
    localparam logic [1:0]  OP_READ     = 2'b10;
    localparam logic [1:0]  OP_ERR      = 2'b11;
    localparam logic [31:0] ERR_ILLEGAL = 32'h0000_0001;
    localparam logic [31:0] ERR_TIMEOUT = 32'h0000_0002;

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_WAIT, S_DECODE, S_BUS, S_RESP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [FRAME_W-1:0] r_frame, w_frame_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               r_rx_re, w_rx_re_nxt;
    logic               r_tx_we, w_tx_we_nxt;
    logic [FRAME_W-1:0] r_tx_data, w_tx_data_nxt;
    logic               r_tx_err, w_tx_err_nxt;
    logic [ADDR_W-1:0]  r_reg_addr, w_reg_addr_nxt;
    logic [31:0]        r_reg_wdata, w_reg_wdata_nxt;
    logic               r_reg_we, w_reg_we_nxt;
    logic               r_reg_re, w_reg_re_nxt;
    logic               r_busy, w_busy_nxt;
    logic [7:0]         r_err_cnt, w_err_cnt_nxt;
    logic [1:0]         w_op;
    logic [5:0]         w_addr;

    assign w_op      = r_frame[39:38];
    assign w_addr    = r_frame[37:32];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and next-output logic. Every output is registered from these values.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame;
        w_cnt_nxt       = r_cnt;
        w_tx_we_nxt     = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_tx_err_nxt    = r_tx_err;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = r_reg_we;
        w_reg_re_nxt    = r_reg_re;
        w_err_cnt_nxt   = r_err_cnt;
        case (r_state)
            S_IDLE: begin
                if (!RX_FIFO_EMPTY) w_state_nxt = S_POP;
            end
            S_POP: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_frame_nxt = RX_Fifo_Data;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_NOP: w_state_nxt = S_IDLE;
                    OP_WRITE, OP_READ: begin
                        w_reg_addr_nxt  = ADDR_W'(w_addr);
                        w_reg_wdata_nxt = r_frame[31:0];
                        w_reg_we_nxt    = (w_op == OP_WRITE);
                        w_reg_re_nxt    = (w_op == OP_READ);
                        w_cnt_nxt       = '0;
                        w_state_nxt     = S_BUS;
                    end
                    default: begin
                        w_tx_data_nxt = {OP_ERR, w_addr, ERR_ILLEGAL};
                        w_tx_err_nxt  = 1'b1;
                        w_state_nxt   = S_RESP;
                    end
                endcase
            end
            S_BUS: begin
                if (Reg_Ready) begin
                    w_reg_we_nxt = 1'b0;
                    w_reg_re_nxt = 1'b0;
                    if (r_reg_re) begin
                        w_tx_data_nxt = {OP_READ, w_addr, Reg_RData};
                        w_tx_err_nxt  = 1'b0;
                        w_state_nxt   = S_RESP;
                    end else begin
`ifdef CMD_WRITE_ACK_EN
                        w_tx_data_nxt = {OP_WRITE, w_addr, r_frame[31:0]};
                        w_tx_err_nxt  = 1'b0;
                        w_state_nxt   = S_RESP;
`else
                        w_state_nxt   = S_IDLE;
`endif
                    end
                end else if (w_cnt_inc >= TIMEOUT_LIM) begin
                    // Bus never answered: abandon the access and report it.
                    w_reg_we_nxt  = 1'b0;
                    w_reg_re_nxt  = 1'b0;
                    w_tx_data_nxt = {OP_ERR, w_addr, ERR_TIMEOUT};
                    w_tx_err_nxt  = 1'b1;
                    w_state_nxt   = S_RESP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                if (!TX_FIFO_FULL) begin
                    w_tx_we_nxt = 1'b1;
                    if (r_tx_err && (r_err_cnt != 8'hFF)) w_err_cnt_nxt = r_err_cnt + 8'd1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_rx_re_nxt = (w_state_nxt == S_POP);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            r_frame     <= '0;
            r_cnt       <= '0;
            r_rx_re     <= 1'b0;
            r_tx_we     <= 1'b0;
            r_tx_data   <= '0;
            r_tx_err    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_frame     <= w_frame_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rx_re     <= w_rx_re_nxt;
            r_tx_we     <= w_tx_we_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_err    <= w_tx_err_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_reg_re    <= w_reg_re_nxt;
            r_busy      <= w_busy_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign RX_FIFO_RE   = r_rx_re;
    assign TX_FIFO_WE   = r_tx_we;
    assign TX_Fifo_Data = r_tx_data;
    assign Reg_Addr     = r_reg_addr;
    assign Reg_WData    = r_reg_wdata;
    assign Reg_WE       = r_reg_we;
    assign Reg_RE       = r_reg_re;
    assign Busy         = r_busy;
    assign Error_Count  = r_err_cnt;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Testbench for uart_command_decoder: directed scenarios plus a randomized
// back-to-back run, checked against a frame-level reference model.
module tb_uart_command_decoder;

    localparam int TMO = 255;

    logic        Clock = 1'b0;
    logic        Reset_N;
    logic        RX_FIFO_EMPTY;
    logic        RX_FIFO_RE;
    logic [39:0] RX_Fifo_Data;
    logic        TX_FIFO_FULL;
    logic        TX_FIFO_WE;
    logic [39:0] TX_Fifo_Data;
    logic [5:0]  Reg_Addr;
    logic [31:0] Reg_WData;
    logic        Reg_WE;
    logic        Reg_RE;
    logic [31:0] Reg_RData;
    logic        Reg_Ready;
    logic        Busy;
    logic [7:0]  Error_Count;

    always #5 Clock = ~Clock;

    uart_command_decoder #(.ADDR_W(6), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset_N(Reset_N),
        .RX_FIFO_EMPTY(RX_FIFO_EMPTY), .RX_FIFO_RE(RX_FIFO_RE), .RX_Fifo_Data(RX_Fifo_Data),
        .TX_FIFO_FULL(TX_FIFO_FULL), .TX_FIFO_WE(TX_FIFO_WE), .TX_Fifo_Data(TX_Fifo_Data),
        .Reg_Addr(Reg_Addr), .Reg_WData(Reg_WData), .Reg_WE(Reg_WE), .Reg_RE(Reg_RE),
        .Reg_RData(Reg_RData), .Reg_Ready(Reg_Ready), .Busy(Busy), .Error_Count(Error_Count)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_err = 0;

    // RX FIFO model: frames written by tests, popped one cycle after RE
    logic [39:0] rx_mem [256];
    logic [7:0]  rx_wr = 8'd0;
    logic [7:0]  rx_rd = 8'd0;
    bit          pop_pending = 1'b0;
    assign RX_FIFO_EMPTY = (rx_wr == rx_rd);

    // Observation logs
    logic [39:0] tx_got[$];
    int          tx_cyc[$];
    logic [39:0] bus_log[$];
    int          str_len[$];
    int          re_count, underflow, full_viol;
    bit          rand_full = 1'b0;

    // Bus responder: per-access ready latency (0 = never) and read data
    int          lat_q[$];
    logic [31:0] rdat_q[$];
    int          bus_age = 0;
    int          cur_lat = 1;
    logic [31:0] cur_rdata = 32'h0;

    // Advance one clock and update FIFO, bus and TX models from the sampled outputs
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (TX_FIFO_WE) begin
            tx_got.push_back(TX_Fifo_Data);
            tx_cyc.push_back(cyc);
            if (TX_FIFO_FULL) full_viol++;
        end
        if (pop_pending) begin
            RX_Fifo_Data = rx_mem[rx_rd];
            rx_rd++;
            pop_pending = 1'b0;
        end
        if (RX_FIFO_RE) begin
            re_count++;
            if (rx_rd == rx_wr) underflow++;
            else pop_pending = 1'b1;
        end
        if (Reg_WE || Reg_RE) begin
            bus_age++;
            if (bus_age == 1) begin
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front(); else cur_lat = 1;
                if (rdat_q.size() > 0) cur_rdata = rdat_q.pop_front(); else cur_rdata = 32'h0;
                bus_log.push_back({Reg_WE, Reg_RE, Reg_Addr, (Reg_WE ? Reg_WData : 32'h0)});
            end
            Reg_Ready = (bus_age == cur_lat);
            Reg_RData = Reg_Ready ? cur_rdata : $urandom();
        end else begin
            if (bus_age > 0) str_len.push_back(bus_age);
            bus_age   = 0;
            Reg_Ready = 1'b0;
            Reg_RData = $urandom();
        end
        if (rand_full) TX_FIFO_FULL = ($urandom_range(0, 3) == 0);
    endtask

    task automatic push_frame(input logic [39:0] f);
        rx_mem[rx_wr] = f;
        rx_wr++;
    endtask

    task automatic clear_logs();
        tx_got.delete(); tx_cyc.delete(); bus_log.delete(); str_len.delete();
        lat_q.delete(); rdat_q.delete();
        re_count = 0; underflow = 0; full_viol = 0;
    endtask

    // Run until the RX FIFO is empty and the DUT has been idle for 3 cycles
    task automatic drain(input int max_cyc, output bit timed_out);
        int quiet;
        quiet = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if ((rx_rd == rx_wr) && !pop_pending && !Busy) quiet++; else quiet = 0;
            if (quiet >= 3) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Reference model: outcome of one frame given the bus ready latency and read data
    function automatic void model(input logic [39:0] f, input int lat, input logic [31:0] rd,
                                  output bit has, output logic [39:0] resp,
                                  output bit is_err, output bit uses_bus);
        logic [1:0] op;
        logic [5:0] a;
        bit         ok;
        op = f[39:38];
        a  = f[37:32];
        ok = (lat >= 1) && (lat <= TMO);
        has = 1'b0; resp = '0; is_err = 1'b0;
        uses_bus = (op == 2'b01) || (op == 2'b10);
        if (op == 2'b11) begin
            has = 1'b1; resp = {2'b11, a, 32'h1}; is_err = 1'b1;
        end else if (uses_bus && !ok) begin
            has = 1'b1; resp = {2'b11, a, 32'h2}; is_err = 1'b1;
        end else if (op == 2'b10) begin
            has = 1'b1; resp = {2'b10, a, rd};
        end else if (op == 2'b01) begin
`ifdef CMD_WRITE_ACK_EN
            has = 1'b1; resp = {2'b01, a, f[31:0]};
`endif
        end
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic test_reset();
        logic [90:0] outs;
        Reset_N = 1'b0;
        repeat (3) tick();
        outs = {RX_FIFO_RE, TX_FIFO_WE, TX_Fifo_Data, Reg_Addr, Reg_WData, Reg_WE, Reg_RE, Busy, Error_Count};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        Reset_N = 1'b1;
        clear_logs();
        repeat (5) tick();
        n_cmp++;
        if ((Busy !== 1'b0) || (re_count != 0)) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b re_count=%0d expected 0/0", Busy, re_count);
        end
    endtask

    task automatic test_read_latency();
        int tp;
        bit to;
        clear_logs();
        lat_q.push_back(1); rdat_q.push_back(32'hDEADBEEF);
        push_frame(40'h82_0000_0000);
        tp = cyc;
        drain(200, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL read_drain: timed out"); end
        n_cmp++;
        if (tx_got.size() != 1) begin n_fail++; $display("FAIL read_tx_count: got %0d expected 1", tx_got.size()); end
        else begin
            n_cmp++;
            if (tx_got[0] !== 40'h82DEADBEEF) begin n_fail++; $display("FAIL read_tx_data: got %h expected 82deadbeef", tx_got[0]); end
            n_cmp++;
            if (tx_cyc[0] - tp != 6) begin n_fail++; $display("FAIL read_latency: got %0d expected 6 (5 after sampling edge)", tx_cyc[0] - tp); end
        end
        n_cmp++;
        if (re_count != 1) begin n_fail++; $display("FAIL read_re_count: got %0d expected 1", re_count); end
    endtask

    task automatic test_write();
        bit to;
        clear_logs();
        lat_q.push_back(3); rdat_q.push_back(32'h0);
        push_frame(40'h45_1234_5678);
        drain(200, to);
        n_cmp++;
        if (bus_log.size() != 1 || bus_log[0] !== {1'b1, 1'b0, 6'h05, 32'h12345678}) begin
            n_fail++; $display("FAIL write_bus: got n=%0d first=%h expected 1 entry 8512345678", bus_log.size(),
                               (bus_log.size() > 0) ? bus_log[0] : 40'h0);
        end
        n_cmp++;
        if (str_len.size() != 1 || str_len[0] != 3) begin
            n_fail++; $display("FAIL write_strobe_len: got n=%0d len=%0d expected 3", str_len.size(),
                               (str_len.size() > 0) ? str_len[0] : -1);
        end
`ifdef CMD_WRITE_ACK_EN
        n_cmp++;
        if (tx_got.size() != 1 || tx_got[0] !== 40'h4512345678) begin
            n_fail++; $display("FAIL write_ack: got n=%0d first=%h expected 4512345678", tx_got.size(),
                               (tx_got.size() > 0) ? tx_got[0] : 40'h0);
        end
`else
        n_cmp++;
        if (tx_got.size() != 0) begin n_fail++; $display("FAIL write_no_resp: got %0d tx writes expected 0", tx_got.size()); end
`endif
        n_cmp++;
        if (Error_Count !== 8'(exp_err)) begin n_fail++; $display("FAIL write_err_cnt: got %0d expected %0d", Error_Count, exp_err); end
    endtask

    task automatic test_illegal();
        bit to;
        clear_logs();
        push_frame(40'hC0_0000_0000);
        drain(200, to);
        exp_err = sat_inc(exp_err);
        n_cmp++;
        if (bus_log.size() != 0) begin n_fail++; $display("FAIL illegal_no_bus: got %0d accesses expected 0", bus_log.size()); end
        n_cmp++;
        if (tx_got.size() != 1 || tx_got[0] !== 40'hC000000001) begin
            n_fail++; $display("FAIL illegal_resp: got n=%0d first=%h expected c000000001", tx_got.size(),
                               (tx_got.size() > 0) ? tx_got[0] : 40'h0);
        end
        n_cmp++;
        if (Error_Count !== 8'(exp_err)) begin n_fail++; $display("FAIL illegal_err_cnt: got %0d expected %0d", Error_Count, exp_err); end
    endtask

    task automatic test_timeout();
        bit to;
        clear_logs();
        lat_q.push_back(0); rdat_q.push_back(32'h0);
        push_frame(40'hBF_0000_0000);
        drain(800, to);
        exp_err = sat_inc(exp_err);
        n_cmp++;
        if (str_len.size() != 1 || str_len[0] != TMO) begin
            n_fail++; $display("FAIL timeout_strobe_len: got n=%0d len=%0d expected %0d", str_len.size(),
                               (str_len.size() > 0) ? str_len[0] : -1, TMO);
        end
        n_cmp++;
        if (tx_got.size() != 1 || tx_got[0] !== 40'hFF00000002) begin
            n_fail++; $display("FAIL timeout_resp: got n=%0d first=%h expected ff00000002", tx_got.size(),
                               (tx_got.size() > 0) ? tx_got[0] : 40'h0);
        end
        n_cmp++;
        if (Error_Count !== 8'(exp_err)) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d expected %0d", Error_Count, exp_err); end
    endtask

    task automatic test_tx_full();
        logic [31:0] rd;
        logic [39:0] d0;
        int          we_bad, chg;
        bit          to;
        clear_logs();
        rd = $urandom();
        lat_q.push_back(1); rdat_q.push_back(rd);
        TX_FIFO_FULL = 1'b1;
        push_frame(40'h81_0000_0000);
        repeat (5) tick();
        d0 = TX_Fifo_Data;
        n_cmp++;
        if (d0 !== {2'b10, 6'h01, rd}) begin n_fail++; $display("FAIL full_resp_data: got %h expected %h", d0, {2'b10, 6'h01, rd}); end
        we_bad = 0; chg = 0;
        repeat (20) begin
            tick();
            if (TX_FIFO_WE) we_bad++;
            if (TX_Fifo_Data !== d0) chg++;
        end
        n_cmp++;
        if (we_bad != 0) begin n_fail++; $display("FAIL full_we_held: got %0d WE cycles expected 0", we_bad); end
        n_cmp++;
        if (chg != 0) begin n_fail++; $display("FAIL full_data_stable: got %0d changes expected 0", chg); end
        TX_FIFO_FULL = 1'b0;
        drain(100, to);
        n_cmp++;
        if (tx_got.size() != 1 || tx_got[0] !== d0) begin
            n_fail++; $display("FAIL full_single_pulse: got n=%0d first=%h expected 1 x %h", tx_got.size(),
                               (tx_got.size() > 0) ? tx_got[0] : 40'h0, d0);
        end
        n_cmp++;
        if (full_viol != 0) begin n_fail++; $display("FAIL full_we_violation: got %0d expected 0", full_viol); end
    endtask

    task automatic test_reset_mid_bus();
        logic [39:0] frames[3];
        int          lats[3];
        logic [31:0] rds[3];
        logic [39:0] exp_tx[$];
        logic [90:0] outs;
        bit          has, is_err, ub, to;
        logic [39:0] resp;
        clear_logs();
        lat_q.push_back(0); rdat_q.push_back(32'h0);
        push_frame(40'h8A_0000_0000);
        for (int i = 0; i < 20 && !Reg_RE; i++) tick();
        n_cmp++;
        if (Reg_RE !== 1'b1) begin n_fail++; $display("FAIL rst_bus_reached: Reg_RE=%b expected 1", Reg_RE); end
        Reset_N = 1'b0;
        tick();
        outs = {RX_FIFO_RE, TX_FIFO_WE, TX_Fifo_Data, Reg_Addr, Reg_WData, Reg_WE, Reg_RE, Busy, Error_Count};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        Reset_N = 1'b1;
        exp_err = 0;
        repeat (10) tick();
        n_cmp++;
        if (tx_got.size() != 0) begin n_fail++; $display("FAIL rst_aborted_resp: got %0d tx writes expected 0", tx_got.size()); end
        clear_logs();
        frames[0] = 40'h47_A5A5_0001; lats[0] = 2; rds[0] = 32'h0;
        frames[1] = 40'h89_0000_0000; lats[1] = 1; rds[1] = 32'hCAFE_F00D;
        frames[2] = 40'hD1_0000_0000; lats[2] = 1; rds[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            model(frames[i], lats[i], rds[i], has, resp, is_err, ub);
            if (has) exp_tx.push_back(resp);
            if (is_err) exp_err = sat_inc(exp_err);
            if (ub) begin lat_q.push_back(lats[i]); rdat_q.push_back(rds[i]); end
            push_frame(frames[i]);
        end
        drain(300, to);
        n_cmp++;
        if (re_count != 3) begin n_fail++; $display("FAIL b2b_re_count: got %0d expected 3", re_count); end
        n_cmp++;
        if (tx_got.size() != exp_tx.size()) begin n_fail++; $display("FAIL b2b_tx_count: got %0d expected %0d", tx_got.size(), exp_tx.size()); end
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL b2b_tx[%0d]: got %h expected %h", i, tx_got[i], exp_tx[i]); end
        end
        n_cmp++;
        if (Error_Count !== 8'(exp_err)) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d expected %0d", Error_Count, exp_err); end
    endtask

    task automatic test_random();
        logic [39:0] exp_tx[$];
        logic [39:0] exp_bus[$];
        int          exp_len[$];
        logic [39:0] f, resp;
        logic [1:0]  op;
        logic [31:0] rd;
        int          lat, tmo_used, n;
        bit          has, is_err, ub, to;
        clear_logs();
        tmo_used = 0;
        n = 24;
        for (int i = 0; i < n; i++) begin
            op  = 2'($urandom_range(0, 3));
            f   = {op, 6'($urandom_range(0, 63)), 32'($urandom())};
            lat = 1;
            rd  = $urandom();
            if (op == 2'b01 || op == 2'b10) begin
                if ($urandom_range(0, 9) == 0 && tmo_used < 2) begin
                    lat = 0; tmo_used++;
                end else begin
                    lat = int'($urandom_range(1, 4));
                end
                lat_q.push_back(lat); rdat_q.push_back(rd);
            end
            model(f, lat, rd, has, resp, is_err, ub);
            if (has) exp_tx.push_back(resp);
            if (is_err) exp_err = sat_inc(exp_err);
            if (ub) begin
                exp_bus.push_back({op == 2'b01, op == 2'b10, f[37:32], (op == 2'b01) ? f[31:0] : 32'h0});
                exp_len.push_back((lat == 0) ? TMO : lat);
            end
            push_frame(f);
        end
        rand_full = 1'b1;
        drain(20000, to);
        rand_full = 1'b0;
        TX_FIFO_FULL = 1'b0;
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL rand_drain: timed out"); end
        n_cmp++;
        if (re_count != n || underflow != 0) begin
            n_fail++; $display("FAIL rand_re: got %0d pulses / %0d underflows expected %0d / 0", re_count, underflow, n);
        end
        n_cmp++;
        if (tx_got.size() != exp_tx.size()) begin n_fail++; $display("FAIL rand_tx_count: got %0d expected %0d", tx_got.size(), exp_tx.size()); end
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rand_tx[%0d]: got %h expected %h", i, tx_got[i], exp_tx[i]); end
        end
        n_cmp++;
        if (bus_log.size() != exp_bus.size()) begin n_fail++; $display("FAIL rand_bus_count: got %0d expected %0d", bus_log.size(), exp_bus.size()); end
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
            n_cmp++;
            if (bus_log[i] !== exp_bus[i]) begin n_fail++; $display("FAIL rand_bus[%0d]: got %h expected %h", i, bus_log[i], exp_bus[i]); end
        end
        for (int i = 0; i < exp_len.size() && i < str_len.size(); i++) begin
            n_cmp++;
            if (str_len[i] != exp_len[i]) begin n_fail++; $display("FAIL rand_strobe_len[%0d]: got %0d expected %0d", i, str_len[i], exp_len[i]); end
        end
        n_cmp++;
        if (full_viol != 0) begin n_fail++; $display("FAIL rand_we_while_full: got %0d expected 0", full_viol); end
        n_cmp++;
        if (Error_Count !== 8'(exp_err)) begin n_fail++; $display("FAIL rand_err_cnt: got %0d expected %0d", Error_Count, exp_err); end
    endtask

    initial begin
        Reset_N      = 1'b0;
        RX_Fifo_Data = '0;
        TX_FIFO_FULL = 1'b0;
        Reg_RData    = '0;
        Reg_Ready    = 1'b0;
        test_reset();
        test_read_latency();
        test_write();
        test_illegal();
        test_timeout();
        test_tx_full();
        test_reset_mid_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
